// File: rtl/rv_pipe_control_unit.sv
// rv_pipe_control_unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control pipe, PCSrc, stall/flush and forwarding.
// Optional feature macro RV_ILLEGAL_INSN_EN adds i_funct7_d and o_illegal_e for illegal-encoding reporting.
module rv_pipe_control_unit #(
  parameter int ALUCTRL_W = 4,
  parameter int REG_AW    = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [6:0]           i_op_d,
  input  logic [2:0]           i_funct3_d,
  input  logic                 i_funct7b5_d,
  input  logic [REG_AW-1:0]    i_rs1_d,
  input  logic [REG_AW-1:0]    i_rs2_d,
  input  logic [REG_AW-1:0]    i_rd_d,
  input  logic                 i_branch_cond_e,
`ifdef RV_ILLEGAL_INSN_EN
  input  logic [6:0]           i_funct7_d,
  output logic                 o_illegal_e,
`endif
  output logic [2:0]           o_imm_src_d,
  output logic                 o_stall_f,
  output logic                 o_stall_d,
  output logic                 o_flush_d,
  output logic                 o_flush_e,
  output logic                 o_pc_src_e,
  output logic                 o_jalr_e,
  output logic [1:0]           o_alu_src_a_e,
  output logic                 o_alu_src_b_e,
  output logic [ALUCTRL_W-1:0] o_alu_control_e,
  output logic [2:0]           o_funct3_e,
  output logic [1:0]           o_forward_a_e,
  output logic [1:0]           o_forward_b_e,
  output logic                 o_mem_write_m,
  output logic [2:0]           o_funct3_m,
  output logic                 o_reg_write_w,
  output logic [1:0]           o_result_src_w,
  output logic [REG_AW-1:0]    o_rd_w
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_PC4    = 2'b10;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_WB     = 2'b01;
  localparam logic [1:0] FWD_MEM    = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
  } ctrl_t;

  // ---------------- ID decode ----------------
  ctrl_t      w_ctrl_d;
  logic [2:0] w_imm_src_d;
  logic       w_valid_op_d;
  logic       w_bubble_d;
  logic       w_alt_d;
  alu_op_e    w_alu_op_d;

  // funct7b5 means SUB/SRA for R-type, but only SRAI for I-type (ADDI never subtracts).
  assign w_alt_d = i_funct7b5_d & ((i_op_d == OP_R) | (i_funct3_d == 3'b101));

  always_comb begin
    w_alu_op_d = ALU_ADD;
    case (i_funct3_d)
      3'b000:  w_alu_op_d = w_alt_d ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_op_d = ALU_SLL;
      3'b010:  w_alu_op_d = ALU_SLT;
      3'b011:  w_alu_op_d = ALU_SLTU;
      3'b100:  w_alu_op_d = ALU_XOR;
      3'b101:  w_alu_op_d = w_alt_d ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_op_d = ALU_OR;
      default: w_alu_op_d = ALU_AND;
    endcase
  end

  always_comb begin
    w_ctrl_d     = '0;
    w_imm_src_d  = IMM_I;
    w_valid_op_d = 1'b1;
    case (i_op_d)
      OP_R: begin
        w_ctrl_d.reg_write = 1'b1;
        w_ctrl_d.alu_ctrl  = w_alu_op_d;
      end
      OP_I: begin
        w_ctrl_d.reg_write = 1'b1;
        w_ctrl_d.alu_ctrl  = w_alu_op_d;
        w_ctrl_d.alu_src_b = 1'b1;
      end
      OP_LOAD: begin
        w_ctrl_d.reg_write  = 1'b1;
        w_ctrl_d.result_src = RES_MEM;
        w_ctrl_d.alu_src_b  = 1'b1;
      end
      OP_STORE: begin
        w_ctrl_d.mem_write = 1'b1;
        w_ctrl_d.alu_src_b = 1'b1;
        w_imm_src_d        = IMM_S;
      end
      OP_BR: begin
        w_ctrl_d.branch   = 1'b1;
        w_ctrl_d.alu_ctrl = ALU_SUB;
        w_imm_src_d       = IMM_B;
      end
      OP_JAL: begin
        w_ctrl_d.reg_write  = 1'b1;
        w_ctrl_d.jump       = 1'b1;
        w_ctrl_d.result_src = RES_PC4;
        w_imm_src_d         = IMM_J;
      end
      OP_JALR: begin
        w_ctrl_d.reg_write  = 1'b1;
        w_ctrl_d.jump       = 1'b1;
        w_ctrl_d.jalr       = 1'b1;
        w_ctrl_d.result_src = RES_PC4;
        w_ctrl_d.alu_src_b  = 1'b1;
      end
      OP_LUI: begin
        w_ctrl_d.reg_write = 1'b1;
        w_ctrl_d.alu_src_a = SRC_A_ZERO;
        w_ctrl_d.alu_src_b = 1'b1;
        w_imm_src_d        = IMM_U;
      end
      OP_AUIPC: begin
        w_ctrl_d.reg_write = 1'b1;
        w_ctrl_d.alu_src_a = SRC_A_PC;
        w_ctrl_d.alu_src_b = 1'b1;
        w_imm_src_d        = IMM_U;
      end
      default: w_valid_op_d = 1'b0;
    endcase
  end

`ifdef RV_ILLEGAL_INSN_EN
  logic w_illegal_d;
  logic r_illegal_e;

  always_comb begin
    w_illegal_d = ~w_valid_op_d;
    if ((i_op_d == OP_R) && (i_funct7_d != 7'h00) && (i_funct7_d != 7'h20))
      w_illegal_d = 1'b1;
    if ((i_op_d == OP_I) && (i_funct3_d == 3'b001) && (i_funct7_d != 7'h00))
      w_illegal_d = 1'b1;
    if ((i_op_d == OP_I) && (i_funct3_d == 3'b101) && (i_funct7_d != 7'h00) && (i_funct7_d != 7'h20))
      w_illegal_d = 1'b1;
  end

  assign w_bubble_d  = w_illegal_d;
  assign o_illegal_e = r_illegal_e;
`else
  assign w_bubble_d = ~w_valid_op_d;
`endif

  // ---------------- ID/EX ----------------
  ctrl_t             r_ctrl_e;
  logic [2:0]        r_funct3_e;
  logic [REG_AW-1:0] r_rs1_e;
  logic [REG_AW-1:0] r_rs2_e;
  logic [REG_AW-1:0] r_rd_e;

  logic w_pc_src_e;
  logic w_load_use;
  logic w_flush_e;
  logic w_stall;

  assign w_pc_src_e = (r_ctrl_e.branch & i_branch_cond_e) | r_ctrl_e.jump;
  assign w_load_use = (r_ctrl_e.result_src == RES_MEM) & r_ctrl_e.reg_write & (r_rd_e != '0) &
                      ((r_rd_e == i_rs1_d) | (r_rd_e == i_rs2_d));
  // A taken redirect makes the ID instruction wrong-path, so it wins over a load-use stall.
  assign w_flush_e  = w_pc_src_e | w_load_use;
  assign w_stall    = w_load_use & ~w_pc_src_e;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_flush_e || w_bubble_d) begin
      r_ctrl_e   <= '0;
      r_funct3_e <= '0;
      r_rs1_e    <= '0;
      r_rs2_e    <= '0;
      r_rd_e     <= '0;
    end else begin
      r_ctrl_e   <= w_ctrl_d;
      r_funct3_e <= i_funct3_d;
      r_rs1_e    <= i_rs1_d;
      r_rs2_e    <= i_rs2_d;
      r_rd_e     <= i_rd_d;
    end
  end

`ifdef RV_ILLEGAL_INSN_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_illegal_e <= 1'b0;
    else          r_illegal_e <= w_illegal_d & ~w_flush_e;
  end
`endif

  // ---------------- EX/MEM and MEM/WB ----------------
  logic              r_reg_write_m;
  logic [1:0]        r_result_src_m;
  logic              r_mem_write_m;
  logic [2:0]        r_funct3_m;
  logic [REG_AW-1:0] r_rd_m;
  logic              r_reg_write_w;
  logic [1:0]        r_result_src_w;
  logic [REG_AW-1:0] r_rd_w;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_reg_write_m  <= 1'b0;
      r_result_src_m <= '0;
      r_mem_write_m  <= 1'b0;
      r_funct3_m     <= '0;
      r_rd_m         <= '0;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= '0;
      r_rd_w         <= '0;
    end else begin
      r_reg_write_m  <= r_ctrl_e.reg_write;
      r_result_src_m <= r_ctrl_e.result_src;
      r_mem_write_m  <= r_ctrl_e.mem_write;
      r_funct3_m     <= r_funct3_e;
      r_rd_m         <= r_rd_e;
      r_reg_write_w  <= r_reg_write_m;
      r_result_src_w <= r_result_src_m;
      r_rd_w         <= r_rd_m;
    end
  end

  // ---------------- forwarding ----------------
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              rw_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              rw_w,
    input logic [REG_AW-1:0] rd_w
  );
    if (rw_m && (rd_m != '0) && (rd_m == rs))      return FWD_MEM;
    else if (rw_w && (rd_w != '0) && (rd_w == rs)) return FWD_WB;
    else                                           return FWD_RF;
  endfunction

  assign o_forward_a_e = fwd_sel(r_rs1_e, r_reg_write_m, r_rd_m, r_reg_write_w, r_rd_w);
  assign o_forward_b_e = fwd_sel(r_rs2_e, r_reg_write_m, r_rd_m, r_reg_write_w, r_rd_w);

  // ---------------- outputs ----------------
  assign o_imm_src_d     = w_imm_src_d;
  assign o_stall_f       = w_stall;
  assign o_stall_d       = w_stall;
  assign o_flush_d       = w_pc_src_e;
  assign o_flush_e       = w_flush_e;
  assign o_pc_src_e      = w_pc_src_e;
  assign o_jalr_e        = r_ctrl_e.jalr;
  assign o_alu_src_a_e   = r_ctrl_e.alu_src_a;
  assign o_alu_src_b_e   = r_ctrl_e.alu_src_b;
  assign o_alu_control_e = ALUCTRL_W'(r_ctrl_e.alu_ctrl);
  assign o_funct3_e      = r_funct3_e;
  assign o_mem_write_m   = r_mem_write_m;
  assign o_funct3_m      = r_funct3_m;
  assign o_reg_write_w   = r_reg_write_w;
  assign o_result_src_w  = r_result_src_w;
  assign o_rd_w          = r_rd_w;

endmodule
